// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the EX-stage control and the multiply/divide unit.
interface mul_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             Start;
    logic [2:0]       MDFn;
    logic [WIDTH-1:0] In1;
    logic [WIDTH-1:0] In2;
    logic             Flush;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output Start, MDFn, In1, In2, Flush,
        input  Busy, Done, HI, LO
    );

    modport slave (
        input  Start, MDFn, In1, In2, Flush,
        output Busy, Done, HI, LO
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU (one bit per cycle) plus single-cycle MTHI/MTLO
// into the architectural HI/LO registers.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic           Clk,
    input  logic           Rst,
    mul_div_unit_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_acc_q, hi_acc_d;   // product upper half / partial remainder
    logic [WIDTH-1:0] lo_acc_q, lo_acc_d;   // multiplier / dividend shifting into quotient
    logic [WIDTH-1:0] opb_q, opb_d;         // multiplicand / divisor magnitude
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d; // negate product or quotient
    logic             neg_rem_q, neg_rem_d; // remainder takes dividend sign
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             signed_op, a_neg, b_neg;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift, div_diff;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    // Datapath step values and next-state selection
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_acc_d  = hi_acc_q;
        lo_acc_d  = lo_acc_q;
        opb_d     = opb_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        signed_op = ~bus.MDFn[0];
        a_neg     = signed_op & bus.In1[WIDTH-1];
        b_neg     = signed_op & bus.In2[WIDTH-1];

        // Shift-add: add multiplicand when the multiplier LSB is set, then
        // shift the whole {acc, multiplier} pair right by one.
        mul_sum = {1'b0, hi_acc_q} + (lo_acc_q[0] ? {1'b0, opb_q} : '0);

        // Restoring divide: the working remainder is WIDTH+1 bits; the stored
        // remainder always fits WIDTH bits because it stays below the divisor.
        div_shift = {hi_acc_q, lo_acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};

        product  = neg_res_q ? -{hi_acc_q, lo_acc_q} : {hi_acc_q, lo_acc_q};
        quot_fix = neg_res_q ? -lo_acc_q : lo_acc_q;
        rem_fix  = neg_rem_q ? -hi_acc_q : hi_acc_q;

        case (state_q)
            IDLE: begin
                if (bus.Start && !bus.Flush) begin
                    case (bus.MDFn)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            hi_acc_d  = '0;
                            lo_acc_d  = a_neg ? -bus.In1 : bus.In1;
                            opb_d     = b_neg ? -bus.In2 : bus.In2;
                            is_div_d  = bus.MDFn[1];
                            neg_res_d = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                            cnt_d     = '0;
                            busy_d    = 1'b1;
                            state_d   = CALC;
                        end
                        3'd4:    hi_d = bus.In1;
                        3'd5:    lo_d = bus.In1;
                        default: ;
                    endcase
                end
            end
            CALC: begin
                if (bus.Flush) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (is_div_q) begin
                        if (!div_diff[WIDTH]) begin
                            hi_acc_d = div_diff[WIDTH-1:0];
                            lo_acc_d = {lo_acc_q[WIDTH-2:0], 1'b1};
                        end else begin
                            hi_acc_d = div_shift[WIDTH-1:0];
                            lo_acc_d = {lo_acc_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        hi_acc_d = mul_sum[WIDTH:1];
                        lo_acc_d = {mul_sum[0], lo_acc_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                if (!bus.Flush) begin
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end else begin
                        hi_d = product[2*WIDTH-1:WIDTH];
                        lo_d = product[WIDTH-1:0];
                    end
                    done_d = 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, accumulators and registered outputs
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_acc_q  <= '0;
            lo_acc_q  <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_acc_q  <= hi_acc_d;
            lo_acc_q  <= lo_acc_d;
            opb_q     <= opb_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.Busy = busy_q;
    assign bus.Done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed bench for mul_div_unit against an arithmetic reference.
module tb_mul_div_unit;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;

    mul_div_unit_if #(.WIDTH(W)) bus();

    mul_div_unit #(.WIDTH(W)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Architectural effect of one instruction on HI/LO, from plain arithmetic.
    function automatic void ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      q, r;
        logic [63:0] p;
        case (f)
            3'd0: begin p = 64'(sa * sb); exp_hi = p[63:32]; exp_lo = p[31:0]; end
            3'd1: begin p = {32'b0, a} * {32'b0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            3'd2: begin
                if (b == 0) begin
                    exp_lo = a[31] ? 32'd1 : 32'hFFFF_FFFF;
                    exp_hi = a;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    exp_lo = q[31:0];
                    exp_hi = r[31:0];
                end
            end
            3'd3: begin
                if (b == 0) begin
                    exp_lo = 32'hFFFF_FFFF;
                    exp_hi = a;
                end else begin
                    exp_lo = a / b;
                    exp_hi = a % b;
                end
            end
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: ;
        endcase
    endfunction

    // Issue one instruction and follow it to completion; ghost >= 0 pulses a
    // competing MULTU that many cycles into the busy window.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input int ghost = -1);
        int busy_cnt = 0;
        int done_cnt = 0;
        @(negedge clk);
        bus.Start = 1'b1; bus.MDFn = f; bus.In1 = a; bus.In2 = b;
        ref_op(f, a, b);
        @(negedge clk);
        bus.Start = 1'b0;
        if (f >= 3'd4) begin
            check({tag, "_hi"}, 64'(bus.HI), 64'(exp_hi));
            check({tag, "_lo"}, 64'(bus.LO), 64'(exp_lo));
            check({tag, "_busy"}, 64'(bus.Busy), 64'(0));
            return;
        end
        for (int c = 0; c < 60; c++) begin
            if (c == ghost) begin
                bus.Start = 1'b1; bus.MDFn = 3'd1; bus.In1 = $urandom; bus.In2 = $urandom;
            end else begin
                bus.Start = 1'b0;
            end
            if (bus.Busy) busy_cnt++;
            if (bus.Done) begin
                done_cnt++;
                break;
            end
            @(negedge clk);
        end
        bus.Start = 1'b0;
        check({tag, "_busylen"}, 64'(busy_cnt), 64'(33));
        check({tag, "_done"}, 64'(done_cnt), 64'(1));
        check({tag, "_hi"}, 64'(bus.HI), 64'(exp_hi));
        check({tag, "_lo"}, 64'(bus.LO), 64'(exp_lo));
        @(negedge clk);
        check({tag, "_donepulse"}, 64'(bus.Done), 64'(0));
        check({tag, "_idle"}, 64'(bus.Busy), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cnt;
        int done_cnt;
        logic [2:0]  f;
        logic [31:0] a, b;

        rst = 1'b1;
        bus.Start = 1'b0; bus.MDFn = '0; bus.In1 = '0; bus.In2 = '0; bus.Flush = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_hi", 64'(bus.HI), 64'(0));
        check("rst_lo", 64'(bus.LO), 64'(0));
        check("rst_busy", 64'(bus.Busy), 64'(0));
        check("rst_done", 64'(bus.Done), 64'(0));
        rst = 1'b0;

        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        check("multu_max_hiconst", 64'(bus.HI), 64'(32'hFFFF_FFFE));
        run_op(3'd0, 32'hFFFF_FFF9, 32'd3, "mult_neg");
        check("mult_neg_loconst", 64'(bus.LO), 64'(32'hFFFF_FFEB));
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg");
        check("div_neg_loconst", 64'(bus.LO), 64'(32'hFFFF_FFFD));
        run_op(3'd3, 32'd100, 32'd0, "divu_zero");
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(3'd2, 32'h8000_0005, 32'd0, "div_zero_neg");
        run_op(3'd2, 32'd17, 32'd0, "div_zero_pos");

        // MTHI then MTLO on consecutive cycles
        @(negedge clk);
        bus.Start = 1'b1; bus.MDFn = 3'd4; bus.In1 = 32'h1234_5678;
        @(negedge clk);
        exp_hi = 32'h1234_5678;
        check("mthi_hi", 64'(bus.HI), 64'(exp_hi));
        check("mthi_busy", 64'(bus.Busy), 64'(0));
        bus.MDFn = 3'd5; bus.In1 = 32'h9ABC_DEF0;
        @(negedge clk);
        exp_lo = 32'h9ABC_DEF0;
        bus.Start = 1'b0;
        check("mtlo_lo", 64'(bus.LO), 64'(exp_lo));
        check("mtlo_hi", 64'(bus.HI), 64'(exp_hi));
        check("mtlo_busy", 64'(bus.Busy), 64'(0));

        // Flush at iteration 10 of a DIVU
        @(negedge clk);
        bus.Start = 1'b1; bus.MDFn = 3'd3; bus.In1 = 32'd1000; bus.In2 = 32'd7;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (9) @(negedge clk);
        bus.Flush = 1'b1;
        @(negedge clk);
        bus.Flush = 1'b0;
        check("flush_busy", 64'(bus.Busy), 64'(0));
        busy_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.Busy) busy_cnt++;
            if (bus.Done) done_cnt++;
            @(negedge clk);
        end
        check("flush_nobusy", 64'(busy_cnt), 64'(0));
        check("flush_nodone", 64'(done_cnt), 64'(0));
        check("flush_hi", 64'(bus.HI), 64'(exp_hi));
        check("flush_lo", 64'(bus.LO), 64'(exp_lo));

        // Flush together with Start in IDLE suppresses both kinds of issue
        bus.Start = 1'b1; bus.MDFn = 3'd4; bus.In1 = 32'hDEAD_BEEF; bus.Flush = 1'b1;
        @(negedge clk);
        check("flush_mthi_hi", 64'(bus.HI), 64'(exp_hi));
        bus.MDFn = 3'd0;
        @(negedge clk);
        bus.Start = 1'b0; bus.Flush = 1'b0;
        check("flush_mult_busy", 64'(bus.Busy), 64'(0));

        // Second Start while busy must not disturb the first result
        run_op(3'd3, 32'd123_456, 32'd789, "ghost", 4);

        // Asynchronous reset at iteration 20 of a MULT
        @(negedge clk);
        bus.Start = 1'b1; bus.MDFn = 3'd0; bus.In1 = 32'd12345; bus.In2 = 32'hFFFF_0000;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_hi", 64'(bus.HI), 64'(0));
        check("arst_lo", 64'(bus.LO), 64'(0));
        check("arst_busy", 64'(bus.Busy), 64'(0));
        exp_hi = '0; exp_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        run_op(3'd0, 32'd12345, 32'hFFFF_0000, "after_rst");

        // Randomized mix of all function codes with boundary operands sprinkled in
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: a = 32'h8000_0000;
                2: b = 32'hFFFF_FFFF;
                3: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(f, a, b, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
